// File: rtl/data_mem_master.sv
// data_mem_master: request-side sequencer for the DataMemory port.
// Accepts one load/store at a time, issues one or more memory beats,
// assembles/extends load data and returns a response.
// Optional feature macro: MISALIGN_SPLIT_EN (misaligned word/half requests
// are split into byte beats; when undefined they are rejected with an error).
module data_mem_master #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_width,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic              Mem_R_Enable,
  output logic              Mem_W_Enable,
  output logic [1:0]        Mem_R_Width,
  output logic [1:0]        Mem_W_Width,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [31:0]       Mem_W_Data,
  input  logic [31:0]       Mem_R_Data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] W_WORD = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_BYTE = 2'b10;
  localparam logic [1:0] W_RSVD = 2'b11;

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        width_q, width_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       raw_q, raw_d;
  logic              error_q, error_d;
`ifdef MISALIGN_SPLIT_EN
  logic              split_q, split_d;
  logic [1:0]        beat_q, beat_d;
  logic [1:0]        last_q, last_d;
`endif

  logic              misaligned;
  logic [1:0]        beat_width;
  logic [ADDR_W-1:0] beat_addr;
  logic [31:0]       beat_wdata;

  // Sign/zero extension of the assembled raw load bits.
  function automatic logic [31:0] extend(input logic [31:0] raw,
                                         input logic [1:0]  width,
                                         input logic        sgn);
    logic [31:0] r;
    case (width)
      W_WORD:  r = raw;
      W_HALF:  r = sgn ? {{16{raw[15]}}, raw[15:0]} : {16'h0000, raw[15:0]};
      W_BYTE:  r = sgn ? {{24{raw[7]}}, raw[7:0]} : {24'h000000, raw[7:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Misalignment of the incoming request (bytes are always aligned).
  always_comb begin
    misaligned = ((req_width == W_WORD) && (req_addr[1:0] != 2'b00)) ||
                 ((req_width == W_HALF) && req_addr[0]);
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      width_q  <= '0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      raw_q    <= '0;
      error_q  <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
      split_q  <= 1'b0;
      beat_q   <= '0;
      last_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      width_q  <= width_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      raw_q    <= raw_d;
      error_q  <= error_d;
`ifdef MISALIGN_SPLIT_EN
      split_q  <= split_d;
      beat_q   <= beat_d;
      last_q   <= last_d;
`endif
    end
  end

  // Next-state logic: request latch, beat stepping and load capture.
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    width_d  = width_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    raw_d    = raw_q;
    error_d  = error_q;
`ifdef MISALIGN_SPLIT_EN
    split_d  = split_q;
    beat_d   = beat_q;
    last_d   = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          width_d  = req_width;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          raw_d    = '0;
          error_d  = 1'b0;
`ifdef MISALIGN_SPLIT_EN
          split_d  = 1'b0;
          beat_d   = '0;
          last_d   = '0;
`endif
          if (req_width == W_RSVD) begin
            error_d = 1'b1;
            state_d = RESP;
          end else if (misaligned) begin
`ifdef MISALIGN_SPLIT_EN
            split_d = 1'b1;
            last_d  = (req_width == W_WORD) ? 2'd3 : 2'd1;
            state_d = ACCESS;
`else
            error_d = 1'b1;
            state_d = RESP;
`endif
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
`ifdef MISALIGN_SPLIT_EN
        if (split_q) begin
          // Split loads assemble little-endian: beat i fills bits [8i+7:8i].
          if (!write_q) raw_d[{beat_q, 3'b000} +: 8] = Mem_R_Data[7:0];
          if (beat_q == last_q) begin
            beat_d  = '0;
            state_d = RESP;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end else begin
          if (!write_q) raw_d = Mem_R_Data;
          state_d = RESP;
        end
`else
        if (!write_q) raw_d = Mem_R_Data;
        state_d = RESP;
`endif
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat width/address/data for the current ACCESS cycle.
  always_comb begin
    beat_width = width_q;
    beat_addr  = addr_q;
    case (width_q)
      W_WORD:  beat_wdata = wdata_q;
      W_HALF:  beat_wdata = {16'h0000, wdata_q[15:0]};
      W_BYTE:  beat_wdata = {24'h000000, wdata_q[7:0]};
      default: beat_wdata = '0;
    endcase
`ifdef MISALIGN_SPLIT_EN
    if (split_q) begin
      beat_width = W_BYTE;
      beat_addr  = addr_q + ADDR_W'(beat_q);
      beat_wdata = {24'h000000, wdata_q[{beat_q, 3'b000} +: 8]};
    end
`endif
  end

  // Output decode: handshakes, memory port and response.
  always_comb begin
    req_ready    = (state_q == IDLE) && !Reset;
    resp_valid   = (state_q == RESP);
    resp_error   = 1'b0;
    resp_rdata   = '0;
    Mem_R_Enable = 1'b0;
    Mem_W_Enable = 1'b0;
    Mem_R_Width  = '0;
    Mem_W_Width  = '0;
    Mem_Address  = '0;
    Mem_W_Data   = '0;
    case (state_q)
      ACCESS: begin
        Mem_Address = beat_addr;
        if (write_q) begin
          Mem_W_Enable = 1'b1;
          Mem_W_Width  = beat_width;
          Mem_W_Data   = beat_wdata;
        end else begin
          Mem_R_Enable = 1'b1;
          Mem_R_Width  = beat_width;
        end
      end
      RESP: begin
        resp_error = error_q;
        if (!error_q && !write_q) resp_rdata = extend(raw_q, width_q, signed_q);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_mem_master.sv
// Directed self-checking bench for data_mem_master with a byte-array
// DataMemory model. Split-access vectors follow MISALIGN_SPLIT_EN.
module tb_data_mem_master;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_width;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_error;
  logic [31:0] resp_rdata;
  logic        Mem_R_Enable, Mem_W_Enable;
  logic [1:0]  Mem_R_Width, Mem_W_Width;
  logic [31:0] Mem_Address, Mem_W_Data, Mem_R_Data;

  int tests = 0;
  int fails = 0;

  data_mem_master #(.ADDR_W(32)) dut (
    .Clock(Clock), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_width(req_width), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .Mem_R_Enable(Mem_R_Enable), .Mem_W_Enable(Mem_W_Enable),
    .Mem_R_Width(Mem_R_Width), .Mem_W_Width(Mem_W_Width),
    .Mem_Address(Mem_Address), .Mem_W_Data(Mem_W_Data),
    .Mem_R_Data(Mem_R_Data)
  );

  always #5 Clock = ~Clock;

  // DataMemory model: 256 bytes, combinational read, write on rising edge.
  logic [7:0] mem [0:255];
  logic [7:0] ma;
  assign ma = Mem_Address[7:0];

  always_comb begin
    Mem_R_Data = '0;
    if (Mem_R_Enable) begin
      case (Mem_R_Width)
        2'b00:   Mem_R_Data = {mem[ma+8'd3], mem[ma+8'd2], mem[ma+8'd1], mem[ma]};
        2'b01:   Mem_R_Data = {16'h0000, mem[ma+8'd1], mem[ma]};
        2'b10:   Mem_R_Data = {24'h000000, mem[ma]};
        default: Mem_R_Data = '0;
      endcase
    end
  end

  always @(posedge Clock) begin
    if (Mem_W_Enable) begin
      mem[ma] <= Mem_W_Data[7:0];
      if (Mem_W_Width != 2'b10) mem[ma+8'd1] <= Mem_W_Data[15:8];
      if (Mem_W_Width == 2'b00) begin
        mem[ma+8'd2] <= Mem_W_Data[23:16];
        mem[ma+8'd3] <= Mem_W_Data[31:24];
      end
    end
  end

  typedef struct {
    logic        write;
    logic [1:0]  width;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_beats;
    logic [1:0]  exp_mw;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic w, logic [1:0] wd, logic s, logic [31:0] a,
                              logic [31:0] d, logic [31:0] er, logic ee,
                              int el, int eb, logic [1:0] mw, logic [31:0] ewd);
    vec_t v;
    v.write = w; v.width = wd; v.sgn = s; v.addr = a; v.wdata = d;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el; v.exp_beats = eb;
    v.exp_mw = mw; v.exp_wd = ewd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_mem_idle(input string nm);
    check({nm, "_ren"}, 32'(Mem_R_Enable), 32'd0);
    check({nm, "_wen"}, 32'(Mem_W_Enable), 32'd0);
  endtask

  // Issue one request, follow beats until the response, then handshake it.
  task automatic run_vec(input vec_t v);
    int beats;
    int lat;
    bit done;
    @(negedge Clock);
    req_valid = 1'b1; req_write = v.write; req_width = v.width;
    req_signed = v.sgn; req_addr = v.addr; req_wdata = v.wdata;
    resp_ready = 1'b0;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(negedge Clock);
    req_valid = 1'b0;
    beats = 0; lat = 0; done = 1'b0;
    for (int c = 1; c <= 20 && !done; c++) begin
      if (resp_valid) begin
        lat = c;
        done = 1'b1;
      end else begin
        if (Mem_R_Enable || Mem_W_Enable) begin
          check("beat_wen", 32'(Mem_W_Enable), 32'(v.write));
          check("beat_ren", 32'(Mem_R_Enable), 32'(!v.write));
          if (beats == 0) begin
            check("beat0_addr", Mem_Address, v.addr);
            check("beat0_width", 32'(v.write ? Mem_W_Width : Mem_R_Width), 32'(v.exp_mw));
            if (v.write) check("beat0_wdata", Mem_W_Data, v.exp_wd);
          end
          beats++;
        end
        @(negedge Clock);
      end
    end
    if (!done) check("resp_timeout", 32'd0, 32'd1);
    check("latency", 32'(lat), 32'(v.exp_lat));
    check("beats", 32'(beats), 32'(v.exp_beats));
    check("resp_rdata", resp_rdata, v.exp_rdata);
    check("resp_error", 32'(resp_error), 32'(v.exp_err));
    check("req_ready_resp", 32'(req_ready), 32'd0);
    resp_ready = 1'b1;
    @(negedge Clock);
    resp_ready = 1'b0;
    check("resp_done", 32'(resp_valid), 32'd0);
    check("req_ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    Reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_width = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

    // Aligned and error vectors common to both builds.
    vecs.push_back(mk(1, 2'b00, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 1, 2'b00, 32'hDEADBEEF));
    vecs.push_back(mk(0, 2'b00, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 1, 2'b00, 32'h0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h21, 32'hAAAAAA80, 32'h0,        0, 2, 1, 2'b10, 32'h00000080));
    vecs.push_back(mk(0, 2'b10, 1, 32'h21, 32'h0,        32'hFFFFFF80, 0, 2, 1, 2'b10, 32'h0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h21, 32'h0,        32'h00000080, 0, 2, 1, 2'b10, 32'h0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h40, 32'h55558123, 32'h0,        0, 2, 1, 2'b01, 32'h00008123));
    vecs.push_back(mk(0, 2'b01, 1, 32'h40, 32'h0,        32'hFFFF8123, 0, 2, 1, 2'b01, 32'h0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h40, 32'h0,        32'h00008123, 0, 2, 1, 2'b01, 32'h0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0,        32'h000000EF, 0, 2, 1, 2'b10, 32'h0));
    vecs.push_back(mk(0, 2'b10, 1, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 2, 1, 2'b10, 32'h0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h12, 32'h0,        32'hFFFFDEAD, 0, 2, 1, 2'b01, 32'h0));
    vecs.push_back(mk(0, 2'b11, 0, 32'h10, 32'h0,        32'h0,        1, 1, 0, 2'b00, 32'h0));
    vecs.push_back(mk(1, 2'b11, 0, 32'h10, 32'h12345678, 32'h0,        1, 1, 0, 2'b00, 32'h0));
`ifdef MISALIGN_SPLIT_EN
    vecs.push_back(mk(1, 2'b00, 0, 32'h31, 32'h11223344, 32'h0,        0, 5, 4, 2'b10, 32'h00000044));
    vecs.push_back(mk(0, 2'b00, 0, 32'h31, 32'h0,        32'h11223344, 0, 5, 4, 2'b10, 32'h0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h33, 32'h0,        32'h00001122, 0, 3, 2, 2'b10, 32'h0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h45, 32'hFFFF9ABC, 32'h0,        0, 3, 2, 2'b10, 32'h000000BC));
    vecs.push_back(mk(0, 2'b01, 1, 32'h45, 32'h0,        32'hFFFF9ABC, 0, 3, 2, 2'b10, 32'h0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h46, 32'h0,        32'h0000009A, 0, 2, 1, 2'b10, 32'h0));
`else
    vecs.push_back(mk(0, 2'b01, 0, 32'h03, 32'h0,        32'h0,        1, 1, 0, 2'b00, 32'h0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h31, 32'h11223344, 32'h0,        1, 1, 0, 2'b00, 32'h0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h31, 32'h0,        32'h0,        1, 1, 0, 2'b00, 32'h0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h31, 32'h0,        32'h0,        0, 2, 1, 2'b10, 32'h0));
`endif

    // Reset state.
    repeat (2) @(negedge Clock);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check_mem_idle("rst");
    check("rst_addr", Mem_Address, 32'd0);
    check("rst_wdata", Mem_W_Data, 32'd0);
    Reset = 1'b0;
    @(negedge Clock);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reserved width with the response back-pressured for 5 cycles.
    @(negedge Clock);
    req_valid = 1'b1; req_write = 1'b0; req_width = 2'b11; req_addr = 32'h20;
    @(negedge Clock);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_error", 32'(resp_error), 32'd1);
      check("hold_rdata", resp_rdata, 32'd0);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check_mem_idle("hold");
      @(negedge Clock);
    end
    resp_ready = 1'b1;
    @(negedge Clock);
    resp_ready = 1'b0;
    check("hold_release", 32'(resp_valid), 32'd0);

    // Reset during the single beat of an aligned store.
    req_valid = 1'b1; req_write = 1'b1; req_width = 2'b00;
    req_addr = 32'h50; req_wdata = 32'h55667788;
    @(negedge Clock);
    req_valid = 1'b0;
    check("rsta_wen", 32'(Mem_W_Enable), 32'd1);
    Reset = 1'b1;
    @(negedge Clock);
    check_mem_idle("rsta_drop");
    check("rsta_resp_valid", 32'(resp_valid), 32'd0);
    check("rsta_req_ready", 32'(req_ready), 32'd0);
    Reset = 1'b0;
    @(negedge Clock);
    check("rsta_req_ready_after", 32'(req_ready), 32'd1);
    check("rsta_resp_valid_after", 32'(resp_valid), 32'd0);
    run_vec(mk(0, 2'b00, 0, 32'h50, 32'h0, 32'h55667788, 0, 2, 1, 2'b00, 32'h0));

`ifdef MISALIGN_SPLIT_EN
    // Reset on the second beat of a split store: beats 0 and 1 land, 2 and 3 do not.
    @(negedge Clock);
    req_valid = 1'b1; req_write = 1'b1; req_width = 2'b00;
    req_addr = 32'h61; req_wdata = 32'hCAFEF00D;
    @(negedge Clock);
    req_valid = 1'b0;
    check("rsts_beat0_addr", Mem_Address, 32'h61);
    @(negedge Clock);
    check("rsts_beat1_addr", Mem_Address, 32'h62);
    check("rsts_beat1_wen", 32'(Mem_W_Enable), 32'd1);
    Reset = 1'b1;
    @(negedge Clock);
    check_mem_idle("rsts_drop");
    check("rsts_resp_valid", 32'(resp_valid), 32'd0);
    Reset = 1'b0;
    @(negedge Clock);
    check("rsts_req_ready_after", 32'(req_ready), 32'd1);
    check("rsts_resp_valid_after", 32'(resp_valid), 32'd0);
    run_vec(mk(0, 2'b10, 0, 32'h61, 32'h0, 32'h0000000D, 0, 2, 1, 2'b10, 32'h0));
    run_vec(mk(0, 2'b10, 0, 32'h62, 32'h0, 32'h000000F0, 0, 2, 1, 2'b10, 32'h0));
    run_vec(mk(0, 2'b10, 0, 32'h63, 32'h0, 32'h00000000, 0, 2, 1, 2'b10, 32'h0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
